// File: rtl/libnet_tx_arb_512.sv
// rtl/libnet_tx_arb_512.sv - arbitrates libnet ACK beats and app packets onto the 512-bit sysnet tx stream.
// Optional ACK coalescing/timeout is enabled by defining LIBNET_ACK_COALESCE_EN.
module libnet_tx_arb_512 #(
`ifdef LIBNET_ACK_COALESCE_EN
    parameter int ACK_COALESCE    = 8,
    parameter int ACK_TIMEOUT     = 256,
`endif
    parameter int CURRENT_SEQ_LSB = 344,
    parameter int CURRENT_SEQ_MSB = 375,
    parameter int ACK_FLAG        = 376,
    parameter int SYN_FLAG        = 377
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  seq_expected,
    input  logic         seq_valid,
    input  logic [511:0] app_tdata,
    input  logic [63:0]  app_tkeep,
    input  logic [63:0]  app_tuser,
    input  logic         app_tlast,
    input  logic         app_tvalid,
    output logic         app_tready,
    output logic [511:0] tx_tdata,
    output logic [63:0]  tx_tkeep,
    output logic [63:0]  tx_tuser,
    output logic         tx_tlast,
    output logic         tx_tvalid,
    input  logic         tx_tready,
    output logic [31:0]  ack_sent_cnt,
    output logic [31:0]  app_pkt_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND_ACK = 2'd1, STREAM_APP = 2'd2} state_t;
    typedef enum logic {GRANT_APP = 1'b0, GRANT_ACK = 1'b1} grant_t;

    state_t       state_q, state_d;
    grant_t       last_grant_q, last_grant_d;
    logic [31:0]  last_seq_q, last_seq_d;
    logic         ack_pending_q, ack_pending_d;
    logic [511:0] tx_tdata_q, tx_tdata_d;
    logic [63:0]  tx_tkeep_q, tx_tkeep_d;
    logic [63:0]  tx_tuser_q, tx_tuser_d;
    logic         tx_tlast_q, tx_tlast_d;
    logic         tx_tvalid_q, tx_tvalid_d;
    logic         tx_is_ack_q, tx_is_ack_d;
    logic [31:0]  ack_sent_cnt_q, ack_sent_cnt_d;
    logic [31:0]  app_pkt_cnt_q, app_pkt_cnt_d;

    logic         can_load;
    logic         seq_update;
    logic         ack_load;
    logic         tx_fire;
    logic [511:0] ack_beat;

    always_comb begin
        seq_update = seq_valid && (seq_expected != last_seq_q);
        last_seq_d = seq_update ? seq_expected : last_seq_q;
        ack_beat = '0;
        ack_beat[CURRENT_SEQ_MSB:CURRENT_SEQ_LSB] = last_seq_q;
        ack_beat[ACK_FLAG] = 1'b1;
        ack_beat[SYN_FLAG] = 1'b0;
    end

`ifdef LIBNET_ACK_COALESCE_EN
    localparam int UW = $clog2(ACK_COALESCE + 1);
    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam logic [UW-1:0] UPD_MAX = UW'(ACK_COALESCE);
    localparam logic [AW-1:0] AGE_MAX = AW'(ACK_TIMEOUT - 1);

    logic [UW-1:0] upd_cnt_q, upd_cnt_d;
    logic [AW-1:0] age_cnt_q, age_cnt_d;
    logic          ack_due;

    // Thresholds are judged on the registered counts; a load in the same cycle
    // consumes them, so it must not re-arm the pending flag.
    always_comb begin
        upd_cnt_d = upd_cnt_q;
        age_cnt_d = age_cnt_q;
        if (ack_load) begin
            upd_cnt_d = seq_update ? UW'(1) : '0;
            age_cnt_d = '0;
        end else begin
            if (seq_update && upd_cnt_q != UPD_MAX) upd_cnt_d = upd_cnt_q + 1'b1;
            if (upd_cnt_q != '0 && age_cnt_q != AGE_MAX) age_cnt_d = age_cnt_q + 1'b1;
        end
        ack_due       = !ack_load && (upd_cnt_q == UPD_MAX || age_cnt_q == AGE_MAX);
        ack_pending_d = (ack_pending_q && !ack_load) || ack_due;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_cnt_q <= '0;
            age_cnt_q <= '0;
        end else begin
            upd_cnt_q <= upd_cnt_d;
            age_cnt_q <= age_cnt_d;
        end
    end
`else
    always_comb begin
        ack_pending_d = (ack_pending_q && !ack_load) || seq_update;
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tx_tdata_d   = tx_tdata_q;
        tx_tkeep_d   = tx_tkeep_q;
        tx_tuser_d   = tx_tuser_q;
        tx_tlast_d   = tx_tlast_q;
        tx_tvalid_d  = tx_tvalid_q;
        tx_is_ack_d  = tx_is_ack_q;
        ack_load     = 1'b0;
        app_tready   = 1'b0;
        can_load     = !tx_tvalid_q || tx_tready;
        tx_fire      = tx_tvalid_q && tx_tready;

        if (can_load) tx_tvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_load) begin
                    if (ack_pending_q && (!app_tvalid || last_grant_q == GRANT_APP)) begin
                        state_d      = SEND_ACK;
                        last_grant_d = GRANT_ACK;
                    end else if (app_tvalid) begin
                        state_d      = STREAM_APP;
                        last_grant_d = GRANT_APP;
                    end
                end
            end
            SEND_ACK: begin
                if (can_load) begin
                    ack_load    = 1'b1;
                    tx_tvalid_d = 1'b1;
                    tx_tdata_d  = ack_beat;
                    tx_tkeep_d  = '1;
                    tx_tuser_d  = '0;
                    tx_tlast_d  = 1'b1;
                    tx_is_ack_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            STREAM_APP: begin
                app_tready = can_load;
                if (can_load && app_tvalid) begin
                    tx_tvalid_d = 1'b1;
                    tx_tdata_d  = app_tdata;
                    tx_tkeep_d  = app_tkeep;
                    tx_tuser_d  = app_tuser;
                    tx_tlast_d  = app_tlast;
                    tx_is_ack_d = 1'b0;
                    if (app_tlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ack_sent_cnt_d = ack_sent_cnt_q + {31'b0, tx_fire && tx_is_ack_q};
        app_pkt_cnt_d  = app_pkt_cnt_q + {31'b0, tx_fire && !tx_is_ack_q && tx_tlast_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_APP;
            last_seq_q     <= '0;
            ack_pending_q  <= 1'b0;
            tx_tdata_q     <= '0;
            tx_tkeep_q     <= '0;
            tx_tuser_q     <= '0;
            tx_tlast_q     <= 1'b0;
            tx_tvalid_q    <= 1'b0;
            tx_is_ack_q    <= 1'b0;
            ack_sent_cnt_q <= '0;
            app_pkt_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            last_seq_q     <= last_seq_d;
            ack_pending_q  <= ack_pending_d;
            tx_tdata_q     <= tx_tdata_d;
            tx_tkeep_q     <= tx_tkeep_d;
            tx_tuser_q     <= tx_tuser_d;
            tx_tlast_q     <= tx_tlast_d;
            tx_tvalid_q    <= tx_tvalid_d;
            tx_is_ack_q    <= tx_is_ack_d;
            ack_sent_cnt_q <= ack_sent_cnt_d;
            app_pkt_cnt_q  <= app_pkt_cnt_d;
        end
    end

    assign tx_tdata     = tx_tdata_q;
    assign tx_tkeep     = tx_tkeep_q;
    assign tx_tuser     = tx_tuser_q;
    assign tx_tlast     = tx_tlast_q;
    assign tx_tvalid    = tx_tvalid_q;
    assign ack_sent_cnt = ack_sent_cnt_q;
    assign app_pkt_cnt  = app_pkt_cnt_q;

endmodule

// File: tb/tb_libnet_tx_arb_512.sv
// tb/tb_libnet_tx_arb_512.sv - directed self-checking bench for libnet_tx_arb_512.
module tb_libnet_tx_arb_512;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  seq_expected;
    logic         seq_valid;
    logic [511:0] app_tdata;
    logic [63:0]  app_tkeep;
    logic [63:0]  app_tuser;
    logic         app_tlast;
    logic         app_tvalid;
    logic         app_tready;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tkeep;
    logic [63:0]  tx_tuser;
    logic         tx_tlast;
    logic         tx_tvalid;
    logic         tx_tready;
    logic [31:0]  ack_sent_cnt;
    logic [31:0]  app_pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [511:0] m_data[$];
    logic [63:0]  m_keep[$];
    logic [63:0]  m_user[$];
    logic         m_last[$];
    int           m_cyc[$];

    libnet_tx_arb_512 dut (
        .clk(clk), .reset(reset), .seq_expected(seq_expected), .seq_valid(seq_valid),
        .app_tdata(app_tdata), .app_tkeep(app_tkeep), .app_tuser(app_tuser),
        .app_tlast(app_tlast), .app_tvalid(app_tvalid), .app_tready(app_tready),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser), .tx_tlast(tx_tlast),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .ack_sent_cnt(ack_sent_cnt), .app_pkt_cnt(app_pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && tx_tvalid && tx_tready) begin
            m_data.push_back(tx_tdata);
            m_keep.push_back(tx_tkeep);
            m_user.push_back(tx_tuser);
            m_last.push_back(tx_tlast);
            m_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] app_word(input int pkt, input int beat);
        logic [511:0] w;
        w = '0;
        w[31:0] = {8'hC0, pkt[15:0], beat[7:0]};
        return w;
    endfunction

    function automatic logic [511:0] ack_word(input logic [31:0] s);
        logic [511:0] w;
        w = '0;
        w[375:344] = s;
        w[376] = 1'b1;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        m_data.delete(); m_keep.delete(); m_user.delete(); m_last.delete(); m_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; seq_expected = '0; seq_valid = 1'b0;
        app_tdata = '0; app_tkeep = '0; app_tuser = '0; app_tlast = 1'b0; app_tvalid = 1'b1;
        tx_tready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (tx_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got %0b want 0", tx_tvalid); end
        n_cmp++; if (tx_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got %0b want 0", tx_tlast); end
        n_cmp++; if (tx_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata got %h want 0", tx_tdata[63:0]); end
        n_cmp++; if (tx_tkeep !== '0 || tx_tuser !== '0) begin n_bad++; $display("FAIL reset_keep_user got %h/%h want 0/0", tx_tkeep, tx_tuser); end
        n_cmp++; if (app_tready !== 1'b0) begin n_bad++; $display("FAIL reset_app_tready got %0b want 0", app_tready); end
        n_cmp++; if (ack_sent_cnt !== 32'd0 || app_pkt_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_counters got %0d/%0d want 0/0", ack_sent_cnt, app_pkt_cnt); end
        @(posedge clk); #1;
        reset = 1'b0; app_tvalid = 1'b0;
    endtask

    task automatic test_single_ack();
        logic [511:0] got;
        clear_mon();
        tx_tready = 1'b1; seq_expected = 32'd5; seq_valid = 1'b1;
        repeat (10) tick();
        got = (m_data.size() > 0) ? m_data[0] : '0;
        n_cmp++; if (m_data.size() != 1) begin n_bad++; $display("FAIL single_ack_count got %0d want 1", m_data.size()); end
        n_cmp++; if (got !== ack_word(32'd5)) begin n_bad++; $display("FAIL single_ack_data got seq=%0d ack=%0b syn=%0b want seq=5 ack=1 syn=0", got[375:344], got[376], got[377]); end
        n_cmp++; if (m_data.size() > 0 && (m_last[0] !== 1'b1 || m_keep[0] !== '1 || m_user[0] !== '0)) begin n_bad++; $display("FAIL single_ack_side got last=%0b keep=%h user=%h want 1/ffffffffffffffff/0", m_last[0], m_keep[0], m_user[0]); end
        n_cmp++; if (ack_sent_cnt !== 32'd1) begin n_bad++; $display("FAIL single_ack_cnt got %0d want 1", ack_sent_cnt); end
    endtask

    task automatic test_coalescing();
        logic acc, done;
        clear_mon();
        tx_tready = 1'b0; done = 1'b0;
        app_tdata = 512'h1AB; app_tkeep = 64'hF; app_tuser = 64'h11; app_tlast = 1'b1; app_tvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); acc = app_tvalid && app_tready;
            @(posedge clk); #1;
            if (acc) begin done = 1'b1; app_tvalid = 1'b0; end
        end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL coalesce_app_accept got %0b want 1", done); end
        app_tvalid = 1'b0;
        seq_expected = 32'd1; tick();
        seq_expected = 32'd2; tick();
        seq_expected = 32'd3; tick();
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (tx_tvalid !== 1'b1 || tx_tdata !== 512'h1AB) begin n_bad++; $display("FAIL coalesce_stall_hold got v=%0b d=%h want 1/1ab", tx_tvalid, tx_tdata[31:0]); end
        @(posedge clk); #1;
        tx_tready = 1'b1;
        repeat (10) tick();
        n_cmp++; if (m_data.size() != 2) begin n_bad++; $display("FAIL coalesce_beats got %0d want 2", m_data.size()); end
        n_cmp++; if (m_data.size() > 1 && (m_data[0] !== 512'h1AB || m_data[1] !== ack_word(32'd3))) begin n_bad++; $display("FAIL coalesce_order got %h then seq %0d want 1ab then seq 3", m_data[0][31:0], m_data[1][375:344]); end
        n_cmp++; if (ack_sent_cnt !== 32'd2 || app_pkt_cnt !== 32'd1) begin n_bad++; $display("FAIL coalesce_counters got %0d/%0d want 2/1", ack_sent_cnt, app_pkt_cnt); end
    endtask

    task automatic test_no_split();
        logic acc;
        int beat, base_ack, base_app;
        clear_mon();
        base_ack = int'(ack_sent_cnt); base_app = int'(app_pkt_cnt);
        tx_tready = 1'b1; beat = 0;
        app_tdata = app_word(7, 0); app_tkeep = '1; app_tuser = 64'hBEEF; app_tlast = 1'b0; app_tvalid = 1'b1;
        for (int i = 0; i < 40 && app_tvalid; i++) begin
            @(negedge clk); acc = app_tvalid && app_tready;
            @(posedge clk); #1;
            if (acc) begin
                beat++;
                if (beat == 2) seq_expected = 32'd10;
                if (beat == 4) app_tvalid = 1'b0;
                app_tdata = app_word(7, beat); app_tlast = (beat == 3);
            end
        end
        n_cmp++; if (app_tvalid !== 1'b0) begin n_bad++; $display("FAIL nosplit_app_done got %0d beats want 4", beat); end
        app_tvalid = 1'b0;
        repeat (10) tick();
        n_cmp++; if (m_data.size() != 5) begin n_bad++; $display("FAIL nosplit_beats got %0d want 5", m_data.size()); end
        for (int i = 0; i < 4 && i < m_data.size(); i++) begin
            n_cmp++;
            if (m_data[i] !== app_word(7, i) || m_last[i] !== (i == 3)) begin
                n_bad++; $display("FAIL nosplit_app_beat%0d got %h last=%0b want %h last=%0b", i, m_data[i][31:0], m_last[i], app_word(7, i)[31:0], (i == 3));
            end
        end
        n_cmp++; if (m_data.size() > 4 && m_data[4] !== ack_word(32'd10)) begin n_bad++; $display("FAIL nosplit_ack got seq %0d flag %0b want seq 10 flag 1", m_data[4][375:344], m_data[4][376]); end
        n_cmp++; if (int'(app_pkt_cnt) - base_app != 1 || int'(ack_sent_cnt) - base_ack != 1) begin n_bad++; $display("FAIL nosplit_counters got app+%0d ack+%0d want +1/+1", int'(app_pkt_cnt) - base_app, int'(ack_sent_cnt) - base_ack); end
    endtask

    task automatic test_alternation();
        logic acc, stopping;
        int pkt, beat, ack_i, exp_pkt, exp_beat, napp, base_app, base_ack;
        int upd_cyc[$];
        logic [31:0] upd_val[$];
        clear_mon();
        base_ack = int'(ack_sent_cnt); base_app = int'(app_pkt_cnt);
        tx_tready = 1'b1; pkt = 0; beat = 0; stopping = 1'b0;
        app_tdata = app_word(0, 0); app_tlast = 1'b0; app_tkeep = '1; app_tuser = 64'hBEEF; app_tvalid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk); acc = app_tvalid && app_tready;
            @(posedge clk); #1;
            if (acc) begin
                beat++;
                if (beat == 2) begin beat = 0; pkt++; if (stopping) app_tvalid = 1'b0; end
                app_tdata = app_word(pkt, beat); app_tlast = (beat == 1);
            end
            if (c >= 110) stopping = 1'b1;
            if (c % 10 == 5 && c < 100) begin
                seq_expected = 32'd100 + 32'(upd_val.size());
                upd_val.push_back(seq_expected);
                upd_cyc.push_back(cyc);
            end
            if (stopping && !app_tvalid) break;
        end
        n_cmp++; if (app_tvalid !== 1'b0) begin n_bad++; $display("FAIL alt_terminated got app_tvalid=%0b want 0", app_tvalid); end
        app_tvalid = 1'b0;
        repeat (10) tick();
        ack_i = 0; exp_pkt = 0; exp_beat = 0;
        for (int i = 0; i < m_data.size(); i++) begin
            if (m_data[i][376]) begin
                if (ack_i < upd_val.size()) begin
                    n_cmp++;
                    if (m_data[i][375:344] !== upd_val[ack_i]) begin n_bad++; $display("FAIL alt_ack%0d_seq got %0d want %0d", ack_i, m_data[i][375:344], upd_val[ack_i]); end
                    napp = 0;
                    for (int j = 0; j < i; j++)
                        if (!m_data[j][376] && m_last[j] && m_cyc[j] > upd_cyc[ack_i]) napp++;
                    n_cmp++;
                    if (napp > 1) begin n_bad++; $display("FAIL alt_ack%0d_wait got %0d app packets before ack want at most 1", ack_i, napp); end
                end
                n_cmp++;
                if (i > 0 && m_last[i-1] !== 1'b1) begin n_bad++; $display("FAIL alt_split at entry %0d got prev tlast=0 want 1", i); end
                ack_i++;
            end else begin
                n_cmp++;
                if (m_data[i] !== app_word(exp_pkt, exp_beat)) begin n_bad++; $display("FAIL alt_app_order got %h want %h", m_data[i][31:0], app_word(exp_pkt, exp_beat)[31:0]); end
                exp_beat++;
                if (exp_beat == 2) begin exp_beat = 0; exp_pkt++; end
            end
        end
        n_cmp++; if (ack_i != upd_val.size() || upd_val.size() != 10) begin n_bad++; $display("FAIL alt_ack_count got %0d acks/%0d updates want 10/10", ack_i, upd_val.size()); end
        n_cmp++; if (exp_pkt != pkt || exp_beat != 0) begin n_bad++; $display("FAIL alt_app_delivered got %0d pkts want %0d", exp_pkt, pkt); end
        n_cmp++; if (int'(app_pkt_cnt) - base_app != pkt || int'(ack_sent_cnt) - base_ack != 10) begin n_bad++; $display("FAIL alt_counters got app+%0d ack+%0d want +%0d/+10", int'(app_pkt_cnt) - base_app, int'(ack_sent_cnt) - base_ack, pkt); end
    endtask

    task automatic test_back_to_back_backpressure();
        logic acc, prev_stall, prev_last;
        logic [511:0] prev_data, w;
        int beat, nstall;
        clear_mon();
        tx_tready = 1'b1; beat = 0; prev_stall = 1'b0; nstall = 0; prev_data = '0; prev_last = 1'b0;
        w = '0; w[31:0] = 32'hA;
        app_tdata = w; app_tlast = 1'b0; app_tkeep = '1; app_tuser = 64'h5; app_tvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc = app_tvalid && app_tready;
            if (prev_stall) begin
                nstall++;
                n_cmp++;
                if (tx_tvalid !== 1'b1 || tx_tdata !== prev_data || tx_tlast !== prev_last) begin
                    n_bad++; $display("FAIL bp_stable got v=%0b d=%h l=%0b want 1/%h/%0b", tx_tvalid, tx_tdata[31:0], tx_tlast, prev_data[31:0], prev_last);
                end
            end
            prev_stall = tx_tvalid && !tx_tready;
            prev_data = tx_tdata; prev_last = tx_tlast;
            @(posedge clk); #1;
            tx_tready = !tx_tready;
            if (acc) begin
                beat++;
                if (beat == 4) app_tvalid = 1'b0;
                w = '0; w[31:0] = 32'hA + 32'(beat);
                app_tdata = w; app_tlast = (beat == 3);
            end
        end
        tx_tready = 1'b1; app_tvalid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (m_data.size() != 4) begin n_bad++; $display("FAIL bp_beats got %0d want 4", m_data.size()); end
        for (int i = 0; i < 4 && i < m_data.size(); i++) begin
            w = '0; w[31:0] = 32'hA + 32'(i);
            n_cmp++;
            if (m_data[i] !== w || m_last[i] !== (i == 3)) begin n_bad++; $display("FAIL bp_beat%0d got %h last=%0b want %h last=%0b", i, m_data[i][31:0], m_last[i], w[31:0], (i == 3)); end
        end
        n_cmp++; if (nstall == 0) begin n_bad++; $display("FAIL bp_stall_exercised got %0d stalls want >0", nstall); end
    endtask

    task automatic test_reset_mid_packet();
        logic acc;
        int beat;
        seq_valid = 1'b0; tx_tready = 1'b1; beat = 0;
        app_tdata = app_word(9, 0); app_tlast = 1'b0; app_tkeep = '1; app_tuser = 64'h9; app_tvalid = 1'b1;
        for (int i = 0; i < 30 && beat < 2; i++) begin
            @(negedge clk); acc = app_tvalid && app_tready;
            @(posedge clk); #1;
            if (acc) begin beat++; app_tdata = app_word(9, beat); end
        end
        n_cmp++; if (beat != 2 || tx_tvalid !== 1'b1) begin n_bad++; $display("FAIL rstmid_setup got beats=%0d v=%0b want 2/1", beat, tx_tvalid); end
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++; if (tx_tvalid !== 1'b0 || app_tready !== 1'b0) begin n_bad++; $display("FAIL rstmid_drop got v=%0b rdy=%0b want 0/0", tx_tvalid, app_tready); end
        n_cmp++; if (ack_sent_cnt !== 32'd0 || app_pkt_cnt !== 32'd0) begin n_bad++; $display("FAIL rstmid_counters got %0d/%0d want 0/0", ack_sent_cnt, app_pkt_cnt); end
        @(posedge clk); #1;
        reset = 1'b0; app_tvalid = 1'b0;
        clear_mon();
        repeat (10) tick();
        n_cmp++; if (m_data.size() != 0) begin n_bad++; $display("FAIL rstmid_seq_invalid got %0d beats want 0", m_data.size()); end
    endtask

    initial begin
        test_reset();
        test_single_ack();
        test_coalescing();
        test_no_split();
        test_alternation();
        test_back_to_back_backpressure();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
